// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - drains the async FIFO read port into a burst-framed valid/ready stream
// Bursts are never cut short: dropping en mid-burst finishes fetching the burst, then drains.
module fifo_rd_drain #(
  parameter int datawidth = 8,
  parameter int burst_len = 4,
  parameter int cnt_width = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 en,
  input  logic                 rempty,
  input  logic [datawidth-1:0] rdata,
  output logic                 rinc,
  output logic [datawidth-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic [cnt_width-1:0] words_out
);

  localparam int bw = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [bw-1:0] last_idx = bw'(burst_len - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [1:0]           occ_q, occ_d;
  logic [datawidth-1:0] head_q, head_d;
  logic [datawidth-1:0] tail_q, tail_d;
  logic [bw-1:0]        fcnt_q, fcnt_d;
  logic [bw-1:0]        dcnt_q, dcnt_d;
  logic [cnt_width-1:0] words_q, words_d;
  logic                 push, pop;

  // Fetch depends only on registered state and the FIFO flag, never on m_ready or en.
  assign rinc      = ((state_q == RUN) || (state_q == FINISH)) && !rempty && (occ_q != 2'd2);
  assign push      = rinc;
  assign m_valid   = (occ_q != 2'd0);
  assign pop       = m_valid && m_ready;
  assign m_data    = head_q;
  assign m_last    = m_valid && (dcnt_q == last_idx);
  assign busy      = (state_q != IDLE);
  assign words_out = words_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = rdata;
        else               tail_d = rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = rdata;
        end else begin
          head_d = tail_q;
          tail_d = rdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    fcnt_d  = fcnt_q;
    dcnt_d  = dcnt_q;
    words_d = words_q;
    state_d = state_q;
    if (push) fcnt_d = (fcnt_q == last_idx) ? '0 : fcnt_q + bw'(1);
    if (pop) begin
      dcnt_d  = (dcnt_q == last_idx) ? '0 : dcnt_q + bw'(1);
      words_d = words_q + cnt_width'(1);
    end
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = (fcnt_d == '0) ? DRAIN : FINISH;
      FINISH:  if (push && (fcnt_q == last_idx)) state_d = DRAIN;
      DRAIN:   if (occ_d == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= IDLE;
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
      words_q <= words_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - self-checking bench for fifo_rd_drain (burst_len=4, cnt_width=4)
module tb_fifo_rd_drain;

  logic       rclk, rrst_n, en, rempty, rinc, m_valid, m_ready, m_last, busy;
  logic [7:0] rdata, m_data;
  logic [3:0] words_out;

  logic [7:0] src_mem [0:63];
  logic [6:0] rd_ptr = '0;
  logic [6:0] wr_ptr;

  int checks = 0;
  int errors = 0;

  // Reference: words in flight, delivered count, fetched count.
  logic [7:0] exp_q[$];
  int         fetched = 0;
  int         dlv = 0;
  int         rinc_total = 0;
  int         cyc = 0;
  logic [7:0] log_data [0:63];
  logic       log_last [0:63];
  int         log_cyc  [0:63];
  int         log_n = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  fifo_rd_drain #(.datawidth(8), .burst_len(4), .cnt_width(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .words_out(words_out)
  );

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = src_mem[rd_ptr[5:0]];
  always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 7'd1;

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge rclk) begin
    cyc++;
    if (!rrst_n) begin
      exp_q.delete();
      fetched = 0;
      dlv = 0;
      prev_hold = 1'b0;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_rinc", rinc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_words_out", words_out, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
    end else begin
      chk("m_valid", m_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("m_data", m_data, exp_q[0]);
        chk("m_last", m_last, (dlv % 4) == 3);
      end else begin
        chk("m_last_idle", m_last, 0);
      end
      chk("words_out", words_out, dlv % 16);
      if (rinc) chk("rinc_legal", (!rempty && exp_q.size() < 2), 1);
      if (!busy) chk("no_partial_burst", ((fetched % 4) == 0 && exp_q.size() == 0), 1);
      if (prev_hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
        chk("hold_last", m_last, prev_last);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (m_valid && m_ready && exp_q.size() != 0) begin
        log_data[log_n] = m_data;
        log_last[log_n] = m_last;
        log_cyc[log_n]  = cyc;
        log_n++;
        void'(exp_q.pop_front());
        dlv++;
      end
      if (rinc) begin
        exp_q.push_back(rdata);
        fetched++;
        rinc_total++;
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_src(input logic [7:0] w);
    src_mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 7'd1;
  endtask

  task automatic wait_drained(input string name, input int n, input int budget);
    int k = 0;
    while (!(dlv >= n && !m_valid) && k < budget) begin tick(); k++; end
    chk({name, "_drained"}, (dlv >= n && !m_valid), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_fetched(input string name, input int n, input int budget);
    int k = 0;
    while (fetched < n && k < budget) begin tick(); k++; end
    chk({name, "_fetched"}, fetched >= n, 1);
  endtask

  initial begin
    int base;
    int rsnap;
    int k;
    rrst_n = 1'b1; en = 1'b0; m_ready = 1'b1; wr_ptr = '0;
    #1 rrst_n = 1'b0;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_m_valid", m_valid, 0);
    rrst_n = 1'b1;
    tick();

    // Streaming: 8 words, back-to-back fetch and delivery.
    for (int i = 0; i < 8; i++) push_src(8'h10 + 8'(i));
    en = 1'b1;
    k = 0;
    while (!rinc && k < 10) begin tick(); k++; end
    for (int i = 0; i < 8; i++) begin
      chk("t1_rinc_streak", rinc, 1);
      tick();
    end
    chk("t1_rinc_empty", rinc, 0);
    wait_drained("t1", 8, 40);
    chk("t1_words_out", words_out, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", log_data[i], 8'h10 + 8'(i));
      chk("t1_last", log_last[i], (i == 3 || i == 7));
    end
    chk("t1_back_to_back", log_cyc[7] - log_cyc[0], 7);

    // Backpressure: buffer fills to two, fetch stops, outputs freeze.
    for (int i = 0; i < 6; i++) push_src(8'h20 + 8'(i));
    tick(); tick();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t2_rinc_stalled", rinc, 0);
    chk("t2_valid_frozen", m_valid, 1);
    chk("t2_data_frozen", m_data, 8'h21);
    chk("t2_occ_two", fetched - dlv, 2);
    m_ready = 1'b1;
    wait_drained("t2", 14, 40);
    for (int i = 0; i < 6; i++) begin
      chk("t2_data", log_data[8+i], 8'h20 + 8'(i));
      chk("t2_last", log_last[8+i], (i == 3));
    end

    // en dropped with 2 words of the burst fetched: exactly 2 more, then idle.
    en = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) push_src(8'h30 + 8'(i));
    wait_idle("t3", 40);
    chk("t3_count", log_n, 16);
    chk("t3_data14", log_data[14], 8'h30);
    chk("t3_data15", log_data[15], 8'h31);
    chk("t3_last15", log_last[15], 1);
    chk("t3_words_out", words_out, 0);
    rsnap = rinc_total;
    for (int i = 0; i < 6; i++) tick();
    chk("t3_no_more_rinc", rinc_total, rsnap);
    chk("t3_still_idle", busy, 0);
    chk("t3_fifo_not_empty", rempty, 0);

    // FIFO empties at burst word 3 while finishing; refill completes it.
    push_src(8'h34);
    en = 1'b1;
    wait_fetched("t4", 19, 30);
    en = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_no_rinc_empty", rinc, 0);
      chk("t4_busy", busy, 1);
      tick();
    end
    push_src(8'h35);
    wait_idle("t4", 30);
    for (int i = 0; i < 4; i++) begin
      chk("t4_data", log_data[16+i], 8'h32 + 8'(i));
      chk("t4_last", log_last[16+i], (i == 3));
    end
    chk("t4_words_out", words_out, 4);

    // Reset with two words buffered mid-burst.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_src(8'h40 + 8'(i));
    en = 1'b1;
    k = 0;
    while (!(exp_q.size() == 2 && !rinc) && k < 20) begin tick(); k++; end
    chk("t5_head", m_data, 8'h40);
    chk("t5_full_no_rinc", rinc, 0);
    rrst_n = 1'b0;
    #1;
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_rinc", rinc, 0);
    chk("t5_rst_words", words_out, 0);
    chk("t5_rst_busy", busy, 0);
    tick();
    rrst_n = 1'b1;
    m_ready = 1'b1;
    base = log_n;
    wait_drained("t5", 6, 40);
    for (int i = 0; i < 6; i++) begin
      chk("t5_data", log_data[base+i], 8'h42 + 8'(i));
      chk("t5_last", log_last[base+i], (i == 3));
    end
    chk("t5_words_out", words_out, 6);

    // words_out wraps at 16 with cnt_width=4.
    for (int i = 0; i < 11; i++) push_src(8'h50 + 8'(i));
    wait_drained("t6", 17, 60);
    chk("t6_wrap", words_out, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) push_src(8'h5b + 8'(i));
    wait_idle("t6", 40);
    chk("t6_final_data", log_data[base+19], 8'h5d);
    chk("t6_final_last", log_last[base+19], 1);
    chk("t6_words_out", words_out, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-domain consumer for the async FIFO's read port.
- Pops words using rinc/rempty/rdata and presents them downstream as a valid/ready stream.
- Groups the output into fixed-length bursts marked with m_last.
- On disable it completes the current burst before stopping, so no partial burst is ever emitted.

Parameters:
datawidth, 8, width of FIFO word and m_data
burst_len, 4, words per burst (>=2)
cnt_width, 16, width of total delivered-word counter

Ports:
rclk  input  1  read-domain clock; all state updates on rising edge
rrst_n  input  1  asynchronous active-low reset (one clock, async active-low reset)
en  input  1  run request; level-sensitive
rempty  input  1  FIFO empty flag (rclk domain)
rdata  input  datawidth  FIFO read data; combinational from current raddr, valid whenever rempty=0
rinc  output  1  FIFO pop strobe; word on rdata is consumed at the same rclk edge
m_data  output  datawidth  head word of output buffer
m_valid  output  1  m_data valid
m_ready  input  1  downstream accept
m_last  output  1  head word is the last word of a burst
busy  output  1  state != IDLE
words_out  output  cnt_width  total words handshaken on m_*, wraps modulo 2^cnt_width

Behaviour:
- Output buffer:
  - 2-entry register FIFO; occupancy occ is 0..2.
  - Push when rinc=1: rdata is captured at that edge.
  - Pop when m_valid && m_ready.
  - Simultaneous push and pop leaves occ unchanged; order is preserved.
- rinc:
  - rinc = (state==RUN || state==FINISH) && !rempty && occ<2.
  - rinc is registered-state-derived only; it has no combinational path from m_ready or en.
  - rinc is never asserted while rempty=1.
- Latency and throughput:
  - A word popped at edge t appears on m_data with m_valid=1 after edge t (0 extra cycles).
  - Steady state with occ=1 and m_ready=1 sustains 1 word/cycle.
- Counters:
  - fcnt counts words fetched in the current burst: increments on rinc, wraps at burst_len-1 -> 0.
  - dcnt counts words delivered in the current burst: increments on handshake, wraps at burst_len-1 -> 0.
  - m_last = m_valid && dcnt==burst_len-1.
  - words_out increments by 1 per handshake.
- Hold stability: m_data, m_valid and m_last are stable while m_valid && !m_ready.
- FSM transitions:
  - IDLE: rinc=0. If en=1, go to RUN.
  - RUN: if en=0, let fcnt_next be fcnt after this cycle's rinc. If fcnt_next==0, go to DRAIN; otherwise go to FINISH.
  - FINISH: en is ignored. Fetching continues until the rinc with fcnt==burst_len-1, then go to DRAIN.
  - DRAIN: rinc=0. When occ==0 (including the cycle where the last pop empties it), go to IDLE.
  - Re-asserting en during FINISH or DRAIN has no effect until IDLE is reached. From IDLE, RUN is entered the following cycle.
- Boundaries:
  - rempty=1 in RUN or FINISH: stall with no rinc, and no timeout.
  - m_ready=0 with occ=2: rinc=0 and rempty is not sampled.
  - en toggling mid-burst never truncates a burst.
- Reset (async assert, sync release by system):
  - state=IDLE, occ=0, fcnt=0, dcnt=0, words_out=0.
  - rinc=0, m_valid=0, m_last=0, m_data=0, busy=0.
  - Reset mid-operation discards buffered words.

Test Plan:
- burst_len=4. Model FIFO with 8 words 0x10..0x17, en=1, m_ready=1.
  - Expect rinc on 8 consecutive cycles and m_data 0x10..0x17 back-to-back.
  - Expect m_last on 0x13 and 0x17, and words_out=8.
- Backpressure: m_ready held 0 for 5 cycles mid-stream.
  - Expect occ saturated at 2 and rinc=0.
  - Expect m_data/m_valid/m_last frozen, then in-order resume with no loss or duplicate.
- en dropped after 2 words fetched.
  - Expect FINISH to fetch exactly 2 more words (m_last on 4th), then DRAIN -> IDLE.
  - Expect busy=0 and no further rinc despite rempty=0.
- FIFO runs empty at word 3 of a burst with en=0 (FINISH).
  - Expect no rinc while rempty=1.
  - Refilling 1 word completes the burst with m_last, then IDLE.
- rrst_n pulsed low with occ=2 mid-burst.
  - Expect immediate m_valid=0, rinc=0, words_out=0, busy=0.
  - After release with en=1, the next burst starts with dcnt=0 (m_last on 4th word).
- words_out wrap: cnt_width=4, 17 words delivered -> words_out=1.
